// File: rtl/ti_stop_sequencer_if.sv
// Host/wrapper-side signal bundle for the stop sequencer.
// The slave modport is the sequencer's view; the master modport is the host/wrapper side.
interface ti_stop_sequencer_if #(
  parameter int NUM_CH    = 2,
  parameter int TIMEOUT_W = 16
);
  logic [NUM_CH-1:0]    cfg_ch_mask;
  logic [TIMEOUT_W-1:0] cfg_timeout;
  logic                 cmd_stop;
  logic                 cmd_resume;
  logic [NUM_CH-1:0]    stop_ack;
  logic [NUM_CH-1:0]    stop_req;
  logic                 decouple;
  logic                 quiesced;
  logic                 busy;
  logic                 timeout_err;
  logic [NUM_CH-1:0]    ack_status;

  modport slave (
    input  cfg_ch_mask, cfg_timeout, cmd_stop, cmd_resume, stop_ack,
    output stop_req, decouple, quiesced, busy, timeout_err, ack_status
  );

  modport master (
    output cfg_ch_mask, cfg_timeout, cmd_stop, cmd_resume, stop_ack,
    input  stop_req, decouple, quiesced, busy, timeout_err, ack_status
  );
endinterface

// File: rtl/ti_stop_sequencer.sv
// Stop/resume sequencer for transaction-interruption wrappers: stop_req, acks, decouple, quiesce; reverse on resume.
// All outputs registered; stop_req one cycle after cmd_stop, decouple one cycle after last ack; hung acks abort via timeout.
module ti_stop_sequencer #(
  parameter int NUM_CH        = 2,
  parameter int TIMEOUT_W     = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               aclk,
  input  logic               aresetn,
  ti_stop_sequencer_if.slave bus
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACK,
    SETTLE_ON,
    HOLD,
    SETTLE_OFF,
    WAIT_CLR
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_CH-1:0]    act_mask_q, act_mask_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [NUM_CH-1:0]    stop_req_q, stop_req_d;
  logic                 decouple_q, decouple_d;
  logic                 quiesced_q, quiesced_d;
  logic                 busy_q, busy_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [NUM_CH-1:0]    ack_status_q, ack_status_d;

  logic [NUM_CH-1:0]    acks_masked;
  logic [NUM_CH-1:0]    acks_seen;
  logic                 tmo_expire;

  assign acks_masked = bus.stop_ack & act_mask_q;
  assign acks_seen   = ack_status_q | acks_masked;
  // cnt holds the remaining budget; the cycle that sees 1 is the last allowed one.
  assign tmo_expire  = (tmo_q != '0) && (cnt_q == TIMEOUT_W'(1));

  always_comb begin
    state_d       = state_q;
    act_mask_d    = act_mask_q;
    tmo_d         = tmo_q;
    cnt_d         = cnt_q;
    scnt_d        = scnt_q;
    stop_req_d    = stop_req_q;
    decouple_d    = decouple_q;
    quiesced_d    = quiesced_q;
    busy_d        = busy_q;
    timeout_err_d = timeout_err_q;
    ack_status_d  = ack_status_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_stop && (bus.cfg_ch_mask != '0)) begin
          act_mask_d    = bus.cfg_ch_mask;
          tmo_d         = bus.cfg_timeout;
          cnt_d         = bus.cfg_timeout;
          timeout_err_d = 1'b0;
          ack_status_d  = '0;
          stop_req_d    = bus.cfg_ch_mask;
          busy_d        = 1'b1;
          state_d       = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        ack_status_d = acks_seen;
        // Completion takes priority over a simultaneous timeout.
        if (acks_seen == act_mask_q) begin
          decouple_d = 1'b1;
          scnt_d     = SETTLE_LOAD;
          state_d    = SETTLE_ON;
        end else if (tmo_q != '0) begin
          cnt_d = cnt_q - TIMEOUT_W'(1);
          if (tmo_expire) begin
            stop_req_d    = '0;
            timeout_err_d = 1'b1;
            busy_d        = 1'b0;
            state_d       = IDLE;
          end
        end
      end
      SETTLE_ON: begin
        if (scnt_q == '0) begin
          quiesced_d = 1'b1;
          state_d    = HOLD;
        end else begin
          scnt_d = scnt_q - SW'(1);
        end
      end
      HOLD: begin
        if (bus.cmd_resume) begin
          decouple_d = 1'b0;
          quiesced_d = 1'b0;
          scnt_d     = SETTLE_LOAD;
          state_d    = SETTLE_OFF;
        end
      end
      SETTLE_OFF: begin
        if (scnt_q == '0) begin
          stop_req_d = '0;
          cnt_d      = tmo_q;
          state_d    = WAIT_CLR;
        end else begin
          scnt_d = scnt_q - SW'(1);
        end
      end
      WAIT_CLR: begin
        if (acks_masked == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (tmo_q != '0) begin
          cnt_d = cnt_q - TIMEOUT_W'(1);
          if (tmo_expire) begin
            timeout_err_d = 1'b1;
            busy_d        = 1'b0;
            state_d       = IDLE;
          end
        end
      end
      default: begin
        stop_req_d = '0;
        decouple_d = 1'b0;
        quiesced_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      act_mask_q    <= '0;
      tmo_q         <= '0;
      cnt_q         <= '0;
      scnt_q        <= '0;
      stop_req_q    <= '0;
      decouple_q    <= 1'b0;
      quiesced_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      ack_status_q  <= '0;
    end else begin
      state_q       <= state_d;
      act_mask_q    <= act_mask_d;
      tmo_q         <= tmo_d;
      cnt_q         <= cnt_d;
      scnt_q        <= scnt_d;
      stop_req_q    <= stop_req_d;
      decouple_q    <= decouple_d;
      quiesced_q    <= quiesced_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      ack_status_q  <= ack_status_d;
    end
  end

  assign bus.stop_req    = stop_req_q;
  assign bus.decouple    = decouple_q;
  assign bus.quiesced    = quiesced_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.ack_status  = ack_status_q;

endmodule

// File: tb/tb_ti_stop_sequencer.sv
// Directed bench for ti_stop_sequencer: stop/resume sequencing, timeouts, command corners, async reset.
// Inputs driven and outputs sampled 1ns after each rising edge.
module tb_ti_stop_sequencer;

  localparam int NUM_CH        = 2;
  localparam int TIMEOUT_W     = 16;
  localparam int SETTLE_CYCLES = 4;

  logic aclk;
  logic aresetn;
  int   n_checks;
  int   n_fail;

  ti_stop_sequencer_if #(.NUM_CH(NUM_CH), .TIMEOUT_W(TIMEOUT_W)) bus ();

  ti_stop_sequencer #(
    .NUM_CH       (NUM_CH),
    .TIMEOUT_W    (TIMEOUT_W),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bus.slave)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    aresetn  = 1'b0;
    bus.cfg_ch_mask = '0;
    bus.cfg_timeout = '0;
    bus.cmd_stop    = 1'b0;
    bus.cmd_resume  = 1'b0;
    bus.stop_ack    = '0;

    #12;
    check("rst_stop_req", 32'(bus.stop_req), 0);
    check("rst_decouple", 32'(bus.decouple), 0);
    check("rst_quiesced", 32'(bus.quiesced), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_timeout_err", 32'(bus.timeout_err), 0);
    check("rst_ack_status", 32'(bus.ack_status), 0);
    tick(1);
    aresetn = 1'b1;
    tick(1);

    // Normal stop: acks at cycles 3 and 6.
    bus.cfg_ch_mask = 2'b11;
    bus.cfg_timeout = 16'd100;
    bus.cmd_stop    = 1'b1;
    tick(1);
    bus.cmd_stop = 1'b0;
    check("t1_stop_req_c1", 32'(bus.stop_req), 3);
    check("t1_busy_c1", 32'(bus.busy), 1);
    check("t1_decouple_c1", 32'(bus.decouple), 0);
    tick(2);
    bus.stop_ack = 2'b01;
    tick(1);
    check("t1_ack_status_c4", 32'(bus.ack_status), 1);
    check("t1_decouple_c4", 32'(bus.decouple), 0);
    tick(2);
    bus.stop_ack = 2'b11;
    check("t1_decouple_c6", 32'(bus.decouple), 0);
    tick(1);
    check("t1_decouple_c7", 32'(bus.decouple), 1);
    check("t1_quiesced_c7", 32'(bus.quiesced), 0);
    check("t1_ack_status_c7", 32'(bus.ack_status), 3);
    tick(3);
    check("t1_quiesced_c10", 32'(bus.quiesced), 0);
    tick(1);
    check("t1_quiesced_c11", 32'(bus.quiesced), 1);
    check("t1_busy_c11", 32'(bus.busy), 1);

    // Resume from HOLD; acks drop two cycles after stop_req falls.
    tick(1);
    bus.cmd_resume = 1'b1;
    tick(1);
    bus.cmd_resume = 1'b0;
    check("t2_decouple_r1", 32'(bus.decouple), 0);
    check("t2_quiesced_r1", 32'(bus.quiesced), 0);
    check("t2_stop_req_r1", 32'(bus.stop_req), 3);
    tick(3);
    check("t2_stop_req_r4", 32'(bus.stop_req), 3);
    tick(1);
    check("t2_stop_req_r5", 32'(bus.stop_req), 0);
    check("t2_busy_r5", 32'(bus.busy), 1);
    tick(2);
    bus.stop_ack = 2'b00;
    check("t2_busy_r7", 32'(bus.busy), 1);
    tick(1);
    check("t2_busy_r8", 32'(bus.busy), 0);
    check("t2_timeout_err_r8", 32'(bus.timeout_err), 0);

    // WAIT_ACK timeout with only channel 0 acking.
    bus.cfg_timeout = 16'd10;
    bus.cmd_stop    = 1'b1;
    tick(1);
    bus.cmd_stop = 1'b0;
    bus.stop_ack = 2'b01;
    tick(9);
    check("t3_stop_req_c10", 32'(bus.stop_req), 3);
    check("t3_timeout_err_c10", 32'(bus.timeout_err), 0);
    check("t3_decouple_c10", 32'(bus.decouple), 0);
    tick(1);
    check("t3_stop_req_c11", 32'(bus.stop_req), 0);
    check("t3_timeout_err_c11", 32'(bus.timeout_err), 1);
    check("t3_busy_c11", 32'(bus.busy), 0);
    check("t3_ack_status_c11", 32'(bus.ack_status), 1);
    check("t3_decouple_c11", 32'(bus.decouple), 0);
    bus.stop_ack = 2'b00;

    // Unmasked ack ignored; no timeout.
    bus.cfg_ch_mask = 2'b10;
    bus.cfg_timeout = 16'd0;
    bus.cmd_stop    = 1'b1;
    tick(1);
    bus.cmd_stop = 1'b0;
    bus.stop_ack = 2'b01;
    check("t4_timeout_err_clr", 32'(bus.timeout_err), 0);
    check("t4_stop_req_c1", 32'(bus.stop_req), 2);
    tick(4);
    bus.stop_ack = 2'b11;
    check("t4_decouple_c5", 32'(bus.decouple), 0);
    check("t4_ack_status_c5", 32'(bus.ack_status), 0);
    tick(1);
    check("t4_decouple_c6", 32'(bus.decouple), 1);
    check("t4_ack_status_c6", 32'(bus.ack_status), 2);
    tick(4);
    check("t4_quiesced_c10", 32'(bus.quiesced), 1);

    // cmd_stop in HOLD is ignored.
    bus.cfg_ch_mask = 2'b01;
    bus.cmd_stop    = 1'b1;
    tick(1);
    bus.cmd_stop = 1'b0;
    check("t5_hold_stop_req", 32'(bus.stop_req), 2);
    check("t5_hold_quiesced", 32'(bus.quiesced), 1);
    check("t5_hold_decouple", 32'(bus.decouple), 1);
    bus.cmd_resume = 1'b1;
    tick(1);
    bus.cmd_resume = 1'b0;
    tick(4);
    check("t5_stop_req_off", 32'(bus.stop_req), 0);
    bus.stop_ack = 2'b00;
    tick(1);
    check("t5_busy_idle", 32'(bus.busy), 0);

    // cmd_resume in IDLE, then mask=0 cmd_stop.
    bus.cmd_resume = 1'b1;
    tick(1);
    bus.cmd_resume = 1'b0;
    check("t5_resume_idle_busy", 32'(bus.busy), 0);
    check("t5_resume_idle_req", 32'(bus.stop_req), 0);
    bus.cfg_ch_mask = 2'b00;
    bus.cmd_stop    = 1'b1;
    tick(1);
    bus.cmd_stop = 1'b0;
    check("t5_mask0_busy", 32'(bus.busy), 0);
    check("t5_mask0_req", 32'(bus.stop_req), 0);

    // Stop and resume together: resume dropped. One-cycle ack pulse still counts.
    bus.cfg_ch_mask = 2'b01;
    bus.cmd_stop    = 1'b1;
    bus.cmd_resume  = 1'b1;
    tick(1);
    bus.cmd_stop   = 1'b0;
    bus.cmd_resume = 1'b0;
    check("t5_both_stop_req", 32'(bus.stop_req), 1);
    check("t5_both_busy", 32'(bus.busy), 1);
    tick(1);
    bus.stop_ack = 2'b01;
    tick(1);
    bus.stop_ack = 2'b00;
    check("t5_pulse_decouple", 32'(bus.decouple), 1);
    check("t5_pulse_ack_status", 32'(bus.ack_status), 1);
    tick(4);
    check("t5_pulse_quiesced", 32'(bus.quiesced), 1);
    tick(2);
    check("t5_still_hold_q", 32'(bus.quiesced), 1);
    check("t5_still_hold_dec", 32'(bus.decouple), 1);

    // Asynchronous reset while decoupled.
    aresetn = 1'b0;
    #1;
    check("t6_rst_stop_req", 32'(bus.stop_req), 0);
    check("t6_rst_decouple", 32'(bus.decouple), 0);
    check("t6_rst_quiesced", 32'(bus.quiesced), 0);
    check("t6_rst_busy", 32'(bus.busy), 0);
    check("t6_rst_timeout_err", 32'(bus.timeout_err), 0);
    check("t6_rst_ack_status", 32'(bus.ack_status), 0);
    tick(1);
    aresetn = 1'b1;
    tick(1);

    // Fresh sequence after reset, then WAIT_CLR timeout with acks stuck high.
    bus.cfg_ch_mask = 2'b11;
    bus.cfg_timeout = 16'd5;
    bus.cmd_stop    = 1'b1;
    tick(1);
    bus.cmd_stop = 1'b0;
    bus.stop_ack = 2'b11;
    check("t6_stop_req_c1", 32'(bus.stop_req), 3);
    tick(1);
    check("t6_decouple_c2", 32'(bus.decouple), 1);
    tick(4);
    check("t6_quiesced_c6", 32'(bus.quiesced), 1);
    bus.cmd_resume = 1'b1;
    tick(1);
    bus.cmd_resume = 1'b0;
    tick(4);
    check("t7_stop_req_r5", 32'(bus.stop_req), 0);
    tick(4);
    check("t7_timeout_err_r9", 32'(bus.timeout_err), 0);
    check("t7_busy_r9", 32'(bus.busy), 1);
    tick(1);
    check("t7_timeout_err_r10", 32'(bus.timeout_err), 1);
    check("t7_busy_r10", 32'(bus.busy), 0);
    bus.stop_ack = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
